// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and stage-boundary widths for elastic pipeline registers
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int IF_ID_CTRL_W  = 4;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 8;
  localparam int ID_EX_DATA_W  = 32;
  localparam int EX_MEM_CTRL_W = 6;
  localparam int EX_MEM_DATA_W = 64;

  function automatic logic [1:0] state_occupancy(input state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for performance events
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - elastic inter-stage register with 2-entry skid buffer, flush and stall counter
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                push;
  logic                pop;

  // Handshake outputs come only from the state flop, so in_ready never sees out_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_occupancy(state_q);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Killed entries become bubbles; payload is left alone since only ctrl has side effects.
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = ST_TWO;
          end else if (push && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (pop) begin
            main_ctrl_d = '0;
            state_d     = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(out_valid & ~out_ready),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - scoreboard bench for pipe_skid_reg
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_ctrl;
  logic [31:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] data;
  } item_t;

  item_t       exp_q[$];
  logic [15:0] exp_stall = '0;
  logic [3:0]  exp_sat = '0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  // Advance one clock; the model sees the same inputs the DUT samples at the edge.
  task automatic step();
    int occ;
    bit psh, pp;
    @(posedge clk);
    occ = exp_q.size();
    psh = in_valid && (occ != 2);
    pp  = (occ != 0) && out_ready;
    if ((occ != 0) && !out_ready) begin
      if (exp_stall != 16'hFFFF) exp_stall++;
      if (exp_sat != 4'hF) exp_sat++;
    end
    if (flush) begin
      exp_q.delete();
    end else begin
      if (pp) exp_q.delete(0);
      if (psh) exp_q.push_back('{in_ctrl, in_data});
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_ctrl !== 8'h00 || out_data !== 32'h0) begin errors++; $display("FAIL reset_out: got %h/%h want 00/0", out_ctrl, out_data); end
    checks++; if (occupancy !== 2'd0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_occ_stall: got %0d/%0d want 0/0", occupancy, stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      drive(1'b1, 8'(i), 32'(i));
      step();
      checks++;
      if (exp_q.size() != 1 || out_valid !== 1'b1 || occupancy !== 2'd1) begin
        errors++; $display("FAIL stream_valid[%0d]: got v=%b occ=%0d want v=1 occ=1", i, out_valid, occupancy);
      end else if (out_ctrl !== exp_q[0].ctrl || out_data !== exp_q[0].data) begin
        errors++; $display("FAIL stream_data[%0d]: got %h/%h want %h/%h", i, out_ctrl, out_data, exp_q[0].ctrl, exp_q[0].data);
      end
    end
    drive(1'b0, 8'h0, 32'h0);
    step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0) begin errors++; $display("FAIL stream_bubble: got v=%b ctrl=%h occ=%0d want 0/00/0", out_valid, out_ctrl, occupancy); end
    checks++; if (out_data !== 32'd5) begin errors++; $display("FAIL stream_hold: got %h want 5", out_data); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 8'h21, 32'hA);
    step();
    drive(1'b1, 8'h22, 32'hB);
    step();
    drive(1'b0, 8'h0, 32'h0);
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got occ=%0d rdy=%b want 2/0", occupancy, in_ready); end
    checks++; if (out_data !== 32'hA || out_ctrl !== 8'h21) begin errors++; $display("FAIL bp_head: got %h/%h want 21/a", out_ctrl, out_data); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL bp_stall[%0d]: got %0d want %0d", i, stall_cnt, exp_stall); end
    end
    out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_release: got rdy=%b occ=%0d want 1/1", in_ready, occupancy); end
    checks++; if (exp_q.size() != 1 || out_data !== exp_q[0].data || out_data !== 32'hB) begin errors++; $display("FAIL bp_second: got %h want b", out_data); end
    step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin errors++; $display("FAIL bp_drain: got v=%b ctrl=%h want 0/00", out_valid, out_ctrl); end
  endtask

  task automatic test_flush();
    logic [15:0] stall_before;
    out_ready = 1'b0;
    drive(1'b1, 8'h31, 32'h1);
    step();
    drive(1'b1, 8'h32, 32'h2);
    step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill: got %0d want 2", occupancy); end
    stall_before = stall_cnt;
    drive(1'b1, 8'h3C, 32'hC);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 8'h0, 32'h0);
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_empty: got v=%b ctrl=%h occ=%0d want 0/00/0", out_valid, out_ctrl, occupancy); end
    checks++; if (stall_cnt !== stall_before || stall_cnt !== exp_stall) begin errors++; $display("FAIL flush_stall: got %0d want %0d", stall_cnt, exp_stall); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || out_data === 32'hC) begin errors++; $display("FAIL flush_ghost[%0d]: got v=%b data=%h want no entry", i, out_valid, out_data); end
    end
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    drive(1'b1, 8'h40, 32'h10);
    step();
    drive(1'b1, 8'h41, 32'h11);
    out_ready = 1'b1;
    step();
    drive(1'b0, 8'h0, 32'h0);
    checks++; if (occupancy !== 2'd1 || out_data !== 32'h11) begin errors++; $display("FAIL pushpop: got occ=%0d data=%h want 1/11", occupancy, out_data); end
    checks++; if (exp_q.size() != 1 || out_ctrl !== exp_q[0].ctrl) begin errors++; $display("FAIL pushpop_ctrl: got %h want 41", out_ctrl); end
    step();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    exp_q.delete();
    exp_stall = '0;
    exp_sat = '0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (s_stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_reset: got %0d want 0", s_stall_cnt); end
    out_ready = 1'b0;
    drive(1'b1, 8'h51, 32'h51);
    step();
    drive(1'b0, 8'h0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (s_stall_cnt !== exp_sat) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, s_stall_cnt, exp_sat); end
    end
    checks++; if (s_stall_cnt !== 4'hF || stall_cnt !== exp_stall) begin errors++; $display("FAIL sat_final: got %0d/%0d want 15/%0d", s_stall_cnt, stall_cnt, exp_stall); end
    checks++; if (s_out_valid !== 1'b1 || s_in_ready !== 1'b1 || s_occupancy !== 2'd1 || s_out_ctrl !== 8'h51 || s_out_data !== 32'h51) begin
      errors++; $display("FAIL sat_entry: got v=%b rdy=%b occ=%0d %h/%h want 1/1/1 51/51", s_out_valid, s_in_ready, s_occupancy, s_out_ctrl, s_out_data);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'h61, 32'h61);
    step();
    drive(1'b1, 8'h62, 32'h62);
    step();
    drive(1'b0, 8'h0, 32'h0);
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL ar_fill: got %0d want 2", occupancy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin errors++; $display("FAIL ar_state: got v=%b rdy=%b occ=%0d want 0/1/0", out_valid, in_ready, occupancy); end
    checks++; if (out_ctrl !== 8'h00 || out_data !== 32'h0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL ar_regs: got %h/%h/%0d want 00/0/0", out_ctrl, out_data, stall_cnt); end
    exp_q.delete();
    exp_stall = '0;
    exp_sat = '0;
    #1 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_release: got %b want 1", in_ready); end
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 8'h55, 32'h55);
    step();
    drive(1'b0, 8'h0, 32'h0);
    checks++; if (exp_q.size() != 1 || out_data !== exp_q[0].data || out_valid !== 1'b1) begin errors++; $display("FAIL ar_after: got v=%b data=%h want 1/55", out_valid, out_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_push_pop();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
